// File: rtl/sort_result_serializer_if.sv
// Handshake bundle for sort_result_serializer:
// a 4-element sorted group in, a serial element stream out.
interface sort_result_serializer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] max;
    logic [DATA_W-1:0] second_max;
    logic [DATA_W-1:0] second_min;
    logic [DATA_W-1:0] min;
    logic              descending;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, max, second_max, second_min, min,
        output descending, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, max, second_max, second_min, min,
        input  descending, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort_result_serializer.sv
// Buffers sorted 4-element groups and streams them one element per beat,
// checking each accepted group for correct ordering.
module sort_result_serializer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    sort_result_serializer_if.slave      bus,
    output logic                         order_err,
    input  logic                         err_clr,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic              desc;
        logic [DATA_W-1:0] mx;
        logic [DATA_W-1:0] smx;
        logic [DATA_W-1:0] smn;
        logic [DATA_W-1:0] mn;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [1:0]        idx;
    logic [1:0]        sel;
    logic              push;
    logic              beat;
    logic              pop;
    logic              sorted;
    logic [DATA_W-1:0] elem;

    assign bus.in_ready  = fifo_count < CW'(DEPTH);
    assign bus.out_valid = fifo_count != '0;
    assign push = bus.in_valid && bus.in_ready;
    assign beat = bus.out_valid && bus.out_ready;
    assign pop  = beat && (idx == 2'd3);

    assign sorted = (bus.max >= bus.second_max)
                 && (bus.second_max >= bus.second_min)
                 && (bus.second_min >= bus.min);

    assign head = mem[rd_ptr];
    // Descending order walks the same slots backwards: 3-idx == ~idx.
    assign sel  = head.desc ? ~idx : idx;

    always_comb begin
        elem = head.mn;
        unique case (sel)
            2'd0: elem = head.mn;
            2'd1: elem = head.smn;
            2'd2: elem = head.smx;
            2'd3: elem = head.mx;
        endcase
    end

    assign bus.out_data = bus.out_valid ? elem : '0;
    assign bus.out_last = bus.out_valid && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.descending, bus.max, bus.second_max,
                            bus.second_min, bus.min};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            idx        <= '0;
            fifo_count <= '0;
            order_err  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            // idx wraps 3 -> 0 on the last beat of a group.
            if (beat) idx <= idx + 2'd1;
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end
            if (push && !sorted) begin
                order_err <= 1'b1;
            end else if (err_clr) begin
                order_err <= 1'b0;
            end
        end
    end
endmodule

// File: doc/sort_result_serializer.md
Name: sort_result_serializer

Overview:
Consumer-side companion to even_odd_merge_sorter_wrapper. It accepts one sorted 4-element group per handshake (max, second_max, second_min, min) and buffers groups in a small FIFO. It emits each group as a serial byte stream, one element per beat, over a valid/ready interface, in ascending or descending order. It also checks every accepted group for correct sorting and raises a sticky error flag.

Parameters:
DATA_W, 8, width of each element
DEPTH, 4, FIFO capacity in groups; must be a power of 2 and at least 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  a sorted group is presented
in_ready  output  1  FIFO can accept a group
max  input  DATA_W  largest element
second_max  input  DATA_W  second-largest element
second_min  input  DATA_W  second-smallest element
min  input  DATA_W  smallest element
descending  input  1  order for this group: 1 = max first, 0 = min first; sampled at push
out_valid  output  1  out_data holds a valid beat
out_ready  input  1  downstream accepts the beat
out_data  output  DATA_W  current element
out_last  output  1  current beat is the 4th of its group
order_err  output  1  sticky flag: a mis-sorted group was accepted
err_clr  input  1  synchronous clear of order_err
fifo_count  output  $clog2(DEPTH+1)  number of groups held, including the group being sent

Behaviour:
- Reset (rst=0) takes effect immediately, with no clock needed:
  - FIFO pointers, fifo_count, beat index and order_err clear to 0.
  - out_valid=0, out_last=0, out_data=0, in_ready=1.
  - A group that is partly sent is discarded.
- Push: occurs on the edge where in_valid && in_ready.
  - Stores {descending, max, second_max, second_min, min} at the write pointer.
  - in_ready = (fifo_count < DEPTH). It is registered-state derived, with no combinational path from out_ready. A push is refused when full, even if a pop happens in the same cycle.
- Order check: evaluated on every push. If the check max ≥ second_max ≥ second_min ≥ min (unsigned) fails, order_err is set on that edge.
  - The data is still stored and sent unchanged.
  - order_err holds until err_clr or reset.
  - If err_clr and a failing push occur on the same edge, the set wins.
- Output:
  - out_valid = (fifo_count != 0). It is driven from registers, so the first beat appears in the cycle after the push edge (latency 1).
  - out_data is selected from the head entry by beat index idx (0..3).
  - Ascending order: min, second_min, second_max, max.
  - Descending order (uses the stored descending bit): max, second_max, second_min, min.
  - out_last = out_valid && (idx==3).
- Beat transfer: occurs on an edge with out_valid && out_ready.
  - If idx<3: idx increments.
  - If idx==3: idx returns to 0, the read pointer advances and the head is popped.
  - When another group is queued, its beat 0 follows on the next cycle with no bubble. Full throughput is 1 beat/cycle, i.e. 1 group per 4 cycles.
- Stability: while out_valid && !out_ready, out_data, out_last and idx stay stable. A push in that cycle does not disturb the head.
- Simultaneous push and last-beat pop: fifo_count is unchanged. The new group lands at the write pointer.
- Pointer wrap: pointers wrap modulo DEPTH, and full/empty is determined only from fifo_count.
- State machine: effectively two states, EMPTY (fifo_count==0) and SENDING (idx 0..3). idx is meaningful only when fifo_count != 0.

Test Plan:
- Reset: hold rst=0 for 2 cycles → out_valid=0, in_ready=1, fifo_count=0, order_err=0. Release rst=1 → values unchanged.
- Ascending: push {max=F0, second_max=80, second_min=20, min=05}, descending=0, out_ready=1 → out_data 05,20,80,F0 on 4 consecutive cycles starting the cycle after the push. out_last=1 only on F0. fifo_count returns to 0.
- Descending: same group with descending=1 → F0,80,20,05. Then push a second group with descending=0 during beat 1 of the first → its ascending beats follow the first group's F0 with no idle cycle.
- Backpressure/full (DEPTH=4): out_ready=0, push 5 groups back-to-back → in_ready=0 after the 4th push, fifo_count=4, 5th group held on the inputs. Set out_ready=1 → 16 contiguous beats, 5th group accepted on the edge after the first pop, 20 beats total in push order. Random out_ready stalls keep out_data stable.
- Order error: push {max=10, second_max=20, second_min=08, min=01}, descending=0 → order_err=1 on the push edge. Beats 01,08,20,10 are still sent. order_err stays 1 across later valid groups until a 1-cycle err_clr pulse → 0.
- Reset mid-group: reset asserted after 2 beats of a 3-group backlog → outputs clear immediately without a clock. After release, push {40,30,20,10} ascending → beats start at 10 with idx=0. No stale data appears.
